// File: rtl/shift_pkg.sv
// Shared types for the serial-in / parallel-load receiver.
// Optional feature macro: SHIFT_SIN_PARITY_EN (adds the PARITY state).
package shift_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

`ifdef SHIFT_SIN_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer with registered rising-edge detect.
// sync_o and rise_o are taken from the same pipeline depth, so any two
// instances with equal SYNC_STAGES stay mutually aligned.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] stage_q, stage_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  // Next state: shift the chain, remember the last synchronized value, flag a 0->1 step.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d_i};
    prev_d  = stage_q[SYNC_STAGES-1];
    rise_d  = stage_q[SYNC_STAGES-1] & ~prev_q;
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  // prev_q is one stage past the chain end, matching the latency of rise_q.
  assign sync_o = prev_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/shift_sin_pload_rx.sv
// Serial-in, parallel-load byte receiver with valid/ready output and sticky overrun.
// Optional feature macro: SHIFT_SIN_PARITY_EN (9th bit carries odd parity).
module shift_sin_pload_rx
  import shift_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              sle,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              parity_err,
  output logic              busy
);

  logic sclk_sync, sclk_rise;
  logic sdata_s, sdata_rise;
  logic sle_s, sle_rise;
  logic unused_sig;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sclk),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sdata),
    .sync_o (sdata_s),
    .rise_o (sdata_rise)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sle (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sle),
    .sync_o (sle_s),
    .rise_o (sle_rise)
  );

  // Identical instances keep alignment; these taps are not needed.
  assign unused_sig = ^{sclk_sync, sdata_rise, sle_rise};

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  byte_t      shreg_q, shreg_d;
  byte_t      dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;

  logic       shift_fire;
  logic       byte_done;
  byte_t      new_byte;
  logic       handshake;
  logic       ovr_set;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: sle low always wins and returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (sle_s) state_d = StShift;
      StShift: begin
        if (!sle_s) state_d = StIdle;
`ifdef SHIFT_SIN_PARITY_EN
        else if (sclk_rise && cnt_q == 3'd7) state_d = StParity;
`endif
      end
`ifdef SHIFT_SIN_PARITY_EN
      StParity: begin
        if (!sle_s)         state_d = StIdle;
        else if (sclk_rise) state_d = StShift;
      end
`endif
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Byte completion decode.
  always_comb begin
    shift_fire = (state_q == StShift) && sle_s && sclk_rise;
`ifdef SHIFT_SIN_PARITY_EN
    byte_done  = (state_q == StParity) && sle_s && sclk_rise;
    new_byte   = shreg_q;
`else
    byte_done  = shift_fire && (cnt_q == 3'd7);
    new_byte   = {shreg_q[BYTE_W-2:0], sdata_s};
`endif
    handshake  = dout_valid_q && dout_ready;
    ovr_set    = byte_done && dout_valid_q && !dout_ready;
  end

  // Shift register and bit counter; leaving the frame discards the partial byte.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (!sle_s || state_q == StIdle) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (shift_fire) begin
      cnt_d   = cnt_q + 3'd1;
      shreg_d = {shreg_q[BYTE_W-2:0], sdata_s};
    end
  end

  // Output holding register: a new byte only lands when the old one is gone or leaving now.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    if (byte_done && !ovr_set) begin
      dout_d       = new_byte;
      dout_valid_d = 1'b1;
    end else if (handshake) begin
      dout_valid_d = 1'b0;
    end
    if (ovr_set)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SHIFT_SIN_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Parity flag follows the byte on dout; error when the 9-bit XOR is even.
  always_comb begin
    parity_err_d = parity_err_q;
    if (byte_done && !ovr_set) parity_err_d = ~^{shreg_q, sdata_s};
  end

  // Parity flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_sin_pload_rx.sv
// Directed bench for shift_sin_pload_rx with a frame-level reference model.
// Build with SHIFT_SIN_PARITY_EN defined to exercise the parity variant.
module tb_shift_sin_pload_rx;

  localparam int S = 2;
`ifdef SHIFT_SIN_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sclk, sdata, sle, dout_ready, ovr_clr;
  logic [7:0] dout;
  logic       dout_valid, overrun, parity_err, busy;

  shift_sin_pload_rx #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdata      (sdata),
    .sle        (sle),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: completed frames are scheduled at the pin-level 8th/9th sclk
  // rise plus the synchronizer latency; the model then applies valid/ready rules.
  typedef struct {
    int         due;
    logic [7:0] b;
    logic       pe;
  } comp_t;

  comp_t      pq[$];
  logic [8:0] pin_bits = '0;
  int         pin_n    = 0;
  logic [7:0] m_dout;
  logic       m_valid, m_ovr, m_perr;
  logic [S+1:0] hist;
  comp_t      c;
  bit         done, set;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      pq.delete();
      hist = '0;
    end else begin
      done = 1'b0;
      set  = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        c    = pq.pop_front();
        done = 1'b1;
      end
      if (done) begin
        if (m_valid && !dout_ready) set = 1'b1;
        else begin
          m_dout = c.b; m_perr = c.pe; m_valid = 1'b1;
        end
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
      if (set)          m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      hist = {hist[S:0], sle};
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", dout, m_dout);
      check("dout_valid", dout_valid, m_valid);
      check("overrun", overrun, m_ovr);
      check("parity_err", parity_err, m_perr);
      check("busy", busy, hist[S+1]);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic odd_p(input logic [7:0] b);
    return ~^b;
  endfunction

  // mode 1: exact latency probe; mode 2: raise ready so the handshake meets completion.
  task automatic send_bit(input logic b, input int mode, input logic [7:0] xb);
    bit fire = 1'b0;
    sdata = b;
    wait_neg(S + 1);
    sclk = 1'b1;
    if (sle) begin
      pin_bits = {pin_bits[7:0], b};
      pin_n++;
      if (pin_n == NB) begin
        if (NB == 9) pq.push_back('{due: cyc + S + 2, b: pin_bits[8:1], pe: ~^pin_bits});
        else         pq.push_back('{due: cyc + S + 2, b: pin_bits[7:0], pe: 1'b0});
        pin_n = 0;
        fire  = 1'b1;
      end
    end
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      if (fire && mode == 1 && k == S + 1) check("lat_pre_valid", dout_valid, 1'b0);
      if (fire && mode == 1 && k == S + 2) begin
        check("lat_valid", dout_valid, 1'b1);
        check("lat_dout", dout, xb);
      end
      if (fire && mode == 2 && k == S + 1) dout_ready = 1'b1;
      if (fire && mode == 2 && k == S + 2) begin
        check("col_dout", dout, xb);
        check("col_valid", dout_valid, 1'b1);
        check("col_ovr", overrun, 1'b0);
      end
    end
    sclk = 1'b0;
    wait_neg(S + 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pbit, input int mode);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0 && NB == 8) ? mode : 0, b);
    if (NB == 9) send_bit(pbit, mode, b);
  endtask

  task automatic sle_on();
    sle = 1'b1;
    wait_neg(S + 3);
  endtask

  task automatic sle_off();
    sle   = 1'b0;
    pin_n = 0;
    wait_neg(S + 3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, dout, 8'h00);
    check({tag, "_valid"}, dout_valid, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
    check({tag, "_perr"}, parity_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; sle = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    wait_neg(2);
    chk_en = 1'b1;
    wait_neg(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_neg(2);

    // Single byte, consumer always ready, exact latency.
    dout_ready = 1'b1;
    sle_on();
    send_byte(8'hA5, odd_p(8'hA5), 1);
    check("a5_dout", dout, 8'hA5);
    check("a5_valid_one_cycle", dout_valid, 1'b0);
    sle_off();

    // Overrun: second byte dropped while first unconsumed.
    dout_ready = 1'b0;
    sle_on();
    send_byte(8'h3C, odd_p(8'h3C), 0);
    check("ovr_first_dout", dout, 8'h3C);
    check("ovr_first_valid", dout_valid, 1'b1);
    send_byte(8'hC3, odd_p(8'hC3), 0);
    check("ovr_kept_dout", dout, 8'h3C);
    check("ovr_set", overrun, 1'b1);
    ovr_clr = 1'b1;
    wait_neg(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    dout_ready = 1'b1;
    wait_neg(1);
    dout_ready = 1'b0;
    check("ovr_drained", dout_valid, 1'b0);
    sle_off();

    // Completion coincides with handshake of the previous byte.
    sle_on();
    send_byte(8'h5A, odd_p(8'h5A), 0);
    send_byte(8'h96, odd_p(8'h96), 2);
    check("col_after_dout", dout, 8'h96);
    check("col_after_ovr", overrun, 1'b0);
    sle_off();

    // Aborted frame after 5 bits, then a clean byte.
    dout_ready = 1'b1;
    sle_on();
    for (int i = 0; i < 5; i++) send_bit(i[0], 0, 8'h00);
    sle_off();
    sle_on();
    send_byte(8'h81, odd_p(8'h81), 0);
    check("abort_dout", dout, 8'h81);
    sle_off();

    // Reset mid-byte with sle held high, then a fresh byte.
    sle_on();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 8'h00);
    rst_n = 1'b0;
    pin_n = 0;
    wait_neg(2);
    check_all_zero("midrst");
    rst_n = 1'b1;
    wait_neg(S + 3);
    send_byte(8'hFF, odd_p(8'hFF), 1);
    check("rst_ff_dout", dout, 8'hFF);
    sle_off();

`ifdef SHIFT_SIN_PARITY_EN
    // 8'h01 has odd weight: parity bit 0 is correct, 1 is an error.
    sle_on();
    send_byte(8'h01, 1'b0, 0);
    check("par_ok_dout", dout, 8'h01);
    check("par_ok_err", parity_err, 1'b0);
    send_byte(8'h01, 1'b1, 0);
    check("par_bad_err", parity_err, 1'b1);
    sle_off();
`endif

    wait_neg(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sin_pload_rx.md
SHIFT_SIN_PLOAD_RX -- requirements
Module: shift_sin_pload_rx

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of flip-flop synchronizer stages on sclk/sdata/sle (legal 2..4).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: sclk  input  1  asynchronous serial shift clock from the host; data sampled on its rising edge.
REQ-005 SHALL have port: sdata  input  1  asynchronous serial data, MSB first.
REQ-006 SHALL have port: sle  input  1  asynchronous frame enable; high = frame active.
REQ-007 SHALL have port: dout  output  8  received byte.
REQ-008 SHALL have port: dout_valid  output  1  dout holds an unconsumed byte.
REQ-009 SHALL have port: dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high.
REQ-010 SHALL have port: overrun  output  1  sticky; a completed byte was dropped.
REQ-011 SHALL have port: ovr_clr  input  1  clears overrun.
REQ-012 SHALL have port: parity_err  output  1  parity status of the byte on dout.
REQ-013 SHALL have port: busy  output  1  high while state is SHIFT or PARITY.

Function
REQ-014 SHALL pass sclk, sdata and sle through identical SYNC_STAGES-deep synchronizers so that all three stay mutually aligned.
REQ-015 SHALL detect an sclk rising edge as synchronized sclk high with the previous registered value low.
REQ-016 SHALL implement states IDLE, SHIFT and PARITY; IDLE->SHIFT when synchronized sle is high.
REQ-017 SHALL, in SHIFT, on each detected edge shift synchronized sdata into the LSB of an 8-bit shift register (left shift) and increment a 3-bit bit counter.
REQ-018 SHALL, on the 8th edge, load dout = {shreg[6:0], sdata_sync} on that same clk edge, reset the counter to 0 and stay in SHIFT (back-to-back bytes within one frame).
REQ-019 SHALL make dout_valid rise exactly SYNC_STAGES+1 clk cycles after the first clk edge that samples the 8th sclk high at the pin.
REQ-020 SHALL hold dout and dout_valid stable until a handshake; dout_valid SHALL clear on the handshake cycle unless a new byte completes in that same cycle.
REQ-021 SHALL, when a byte completes with dout_valid high and dout_ready low, discard the new byte, keep the old dout, and set overrun.
REQ-022 SHALL, on simultaneous byte completion and handshake, load the new byte, keep dout_valid high, and not set overrun.
REQ-023 SHALL give a set of overrun priority over ovr_clr in the same cycle.
REQ-024 SHALL, when synchronized sle goes low in any state, return to IDLE, clear the counter, and discard the partial byte with no output change; sclk edges in IDLE SHALL be ignored.
REQ-025 SHALL require sclk high and low phases and sdata setup/hold of at least SYNC_STAGES+1 clk periods each; behaviour outside these limits is unspecified.

Reset
REQ-026 SHALL, with rst_n low at a clk edge, clear the synchronizers, the edge register, the shift register, the counter, dout (8'h00), dout_valid, overrun, parity_err and busy, and enter IDLE.
REQ-027 SHALL, when reset occurs mid-byte, discard the partial byte; an sle already high at reset release SHALL start a fresh frame.

Configuration
REQ-028 SHALL support macro SHIFT_SIN_PARITY_EN; when it is defined, the 8th edge enters PARITY, the 9th edge supplies the odd-parity bit, and dout/parity_err load on the 9th edge, with parity_err = 1 when the XOR of all 9 bits is 0.
REQ-029 SHALL, when SHIFT_SIN_PARITY_EN is undefined, omit the PARITY state, tie parity_err to 0, and load on the 8th edge.

Structure
REQ-030 SHALL take from package shift_pkg: the state enum type, BYTE_W = 8, and the byte typedef.
REQ-031 SHALL place the synchronizer and rising-edge detector in sub-module sync_edge_det, instantiated once per input.

Verification
REQ-032 SHALL cover: sle high, send 8'hA5 MSB first, dout_ready high -> dout = 8'hA5, one-cycle dout_valid, REQ-019 latency exact.
REQ-033 SHALL cover: one frame sending 8'h3C then 8'hC3, dout_ready held low -> dout stays 8'h3C and overrun = 1; ovr_clr -> overrun = 0.
REQ-034 SHALL cover: 2nd byte completes in the handshake cycle of the 1st -> dout switches to the 2nd byte, dout_valid stays 1, overrun = 0.
REQ-035 SHALL cover: sle dropped after 5 bits, new frame 8'h81 -> dout = 8'h81 with no stale bits.
REQ-036 SHALL cover: rst_n pulsed low after 4 bits -> all outputs 0; next full byte 8'hFF is received correctly.
REQ-037 SHALL cover, with SHIFT_SIN_PARITY_EN defined: 8'h01 with parity bit 0 -> parity_err = 0; with parity bit 1 -> parity_err = 1.
